hilo_ctrl: RTL and testbench

- Sequencer that owns the write port of the HI/LO register pair.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage and computes the 64-bit result: single-cycle multiply, iterative 32-step divide.
- Drives the HI/LO write enable and data, and raises a pipeline stall request while a divide is in flight.
- Sits between the EX stage, the HI/LO register and the stall controller.

---
 rtl/hilo_pkg.sv | 21 ++
 rtl/hilo_if.sv | 25 ++
 rtl/hilo_ctrl_div_core.sv | 88 ++++++++
 rtl/hilo_ctrl.sv | 150 +++++++++++++++
 tb/tb_hilo_ctrl.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hilo_pkg.sv
// Shared op codes, FSM state encoding and sizing for the HI/LO write sequencer.
package hilo_pkg;

  localparam int HILO_WIDTH = 32;
  localparam int DIV_CYCLES = 32;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/hilo_if.sv
// EX-stage <-> HI/LO sequencer bundle: operation request, flush, stall and HI/LO write port.
interface hilo_if #(parameter int WIDTH = 32);

  logic               op_valid;
  logic [2:0]         op;
  logic [WIDTH-1:0]   src_a;
  logic [WIDTH-1:0]   src_b;
  logic [WIDTH-1:0]   hi_in;
  logic [WIDTH-1:0]   lo_in;
  logic               flush;
  logic               stall_req;
  logic               hilo_we;
  logic [2*WIDTH-1:0] hilo_data;

  modport master (
    output op_valid, op, src_a, src_b, hi_in, lo_in, flush,
    input  stall_req, hilo_we, hilo_data
  );

  modport slave (
    input  op_valid, op, src_a, src_b, hi_in, lo_in, flush,
    output stall_req, hilo_we, hilo_data
  );

endinterface

// File: rtl/hilo_ctrl_div_core.sv
// Iterative unsigned restoring divider: first step on the start edge, done pulses DIV_CYCLES cycles after start.
module div_core #(
  parameter int WIDTH      = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  logic             r_busy;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;

  logic [WIDTH-1:0] w_rem_in;
  logic [WIDTH-1:0] w_quo_in;
  logic [WIDTH-1:0] w_div_in;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_fits;
  logic [WIDTH-1:0] w_next_rem;
  logic [WIDTH-1:0] w_next_quo;

  // The step datapath works on the fresh operands in the start cycle so the
  // last of the DIV_CYCLES steps lands one cycle earlier.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_rem_in = r_rem;
    w_quo_in = r_quo;
    w_div_in = r_div;
    if (start) begin
      w_rem_in = '0;
      w_quo_in = dividend;
      w_div_in = divisor;
    end
  end

  assign w_shift    = {w_rem_in, w_quo_in[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, w_div_in};
  assign w_fits     = ~w_diff[WIDTH];
  assign w_next_rem = w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_next_quo = {w_quo_in[WIDTH-2:0], w_fits};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
    end else if (abort) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (start) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_busy <= 1'b1;
      r_cnt  <= CW'(DIV_CYCLES - 1);
      r_div  <= divisor;
      r_rem  <= w_next_rem;
      r_quo  <= w_next_quo;
    end else if (r_busy) begin
      if (r_cnt != '0) begin
        r_rem <= w_next_rem;
        r_quo <= w_next_quo;
        r_cnt <= r_cnt - CW'(1);
      end else begin
        r_busy <= 1'b0;
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_busy && (r_cnt == '0);
  assign quotient  = r_quo;
  assign remainder = r_rem;

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO write-port sequencer: single-cycle multiply and MT moves, stalled iterative divide with sign fix-up.
module hilo_ctrl #(
  parameter int WIDTH      = hilo_pkg::HILO_WIDTH,
  parameter int DIV_CYCLES = hilo_pkg::DIV_CYCLES
) (
  input  logic   clk,
  input  logic   rst,
  hilo_if.slave  bus
);

  import hilo_pkg::*;

  state_t r_state;
  state_t w_next;

  logic               r_we;
  logic [2*WIDTH-1:0] r_hilo;
  logic               r_neg_q;
  logic               r_neg_r;

  logic               w_accept;
  logic               w_is_sdiv;
  logic               w_is_div;
  logic               w_div_zero;
  logic               w_div_start;
  logic               w_div_abort;
  logic               w_div_busy;
  logic               w_div_done;
  logic               w_load;
  logic [2*WIDTH-1:0] w_load_data;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [2*WIDTH-1:0] w_mul_s;
  logic [2*WIDTH-1:0] w_mul_u;

  assign w_accept   = (r_state == ST_IDLE) && bus.op_valid && !bus.flush;
  assign w_is_sdiv  = (bus.op == OP_DIV);
  assign w_is_div   = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
  assign w_div_zero = (bus.src_b == '0);

  // Operands pre-extended to 2*WIDTH, so the truncated product is exact for both signednesses.
  assign w_mul_s = {{WIDTH{bus.src_a[WIDTH-1]}}, bus.src_a} * {{WIDTH{bus.src_b[WIDTH-1]}}, bus.src_b};
  assign w_mul_u = {{WIDTH{1'b0}}, bus.src_a} * {{WIDTH{1'b0}}, bus.src_b};

  assign w_abs_a   = (w_is_sdiv && bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
  assign w_abs_b   = (w_is_sdiv && bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;
  assign w_quo_fix = r_neg_q ? -w_quo : w_quo;
  assign w_rem_fix = r_neg_r ? -w_rem : w_rem;

  div_core #(
    .WIDTH      (WIDTH),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div_core (
    .clk       (clk),
    .rst       (rst),
    .start     (w_div_start),
    .abort     (w_div_abort),
    .dividend  (w_abs_a),
    .divisor   (w_abs_b),
    .busy      (w_div_busy),
    .done      (w_div_done),
    .quotient  (w_quo),
    .remainder (w_rem)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && w_is_div) w_next = w_div_zero ? ST_DONE : ST_BUSY;
      ST_BUSY: begin
        if (bus.flush)       w_next = ST_IDLE;
        else if (w_div_done) w_next = ST_DONE;
        else if (!w_div_busy) w_next = ST_IDLE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.stall_req = 1'b0;
    w_div_start   = 1'b0;
    w_div_abort   = 1'b0;
    w_load        = 1'b0;
    w_load_data   = '0;
    case (r_state)
      ST_IDLE: if (w_accept) begin
        case (bus.op)
          OP_MULT:  begin w_load = 1'b1; w_load_data = w_mul_s; end
          OP_MULTU: begin w_load = 1'b1; w_load_data = w_mul_u; end
          OP_MTHI:  begin w_load = 1'b1; w_load_data = {bus.src_a, bus.lo_in}; end
          OP_MTLO:  begin w_load = 1'b1; w_load_data = {bus.hi_in, bus.src_a}; end
          OP_DIV, OP_DIVU: begin
            bus.stall_req = 1'b1;
            if (w_div_zero) begin
              w_load      = 1'b1;
              w_load_data = {bus.src_a, {WIDTH{1'b1}}};
            end else begin
              w_div_start = 1'b1;
            end
          end
          default: ;
        endcase
      end
      ST_BUSY: begin
        if (bus.flush) begin
          w_div_abort = 1'b1;
        end else begin
          bus.stall_req = 1'b1;
          if (w_div_done) begin
            w_load      = 1'b1;
            w_load_data = {w_rem_fix, w_quo_fix};
          end
        end
      end
      default: ;
    endcase
    // Reset must drop the stall at once, even if the EX stage still shows a divide.
    if (!rst) bus.stall_req = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we    <= 1'b0;
      r_hilo  <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      r_we <= w_load;
      if (w_load) r_hilo <= w_load_data;
      if (w_div_start) begin
        r_neg_q <= w_is_sdiv && (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
        r_neg_r <= w_is_sdiv && bus.src_a[WIDTH-1];
      end
    end
  end

  assign bus.hilo_we   = r_we & ~bus.flush;
  assign bus.hilo_data = r_hilo;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Self-checking bench for hilo_ctrl: directed scenarios plus randomized ops against a plain-arithmetic HI/LO model.
module tb_hilo_ctrl;

  localparam int W = 32;
  localparam logic [2:0] OP_NOP = 3'b000, OP_MULT = 3'b001, OP_MULTU = 3'b010, OP_DIV = 3'b011,
                         OP_DIVU = 3'b100, OP_MTHI = 3'b101, OP_MTLO = 3'b110, OP_RSV = 3'b111;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  hilo_if #(.WIDTH(W)) bus();

  hilo_ctrl #(.WIDTH(W), .DIV_CYCLES(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference: what HI/LO should become, from the ISA rules with plain 64-bit arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a, b, hi, lo);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ref_result = '0;
    case (op)
      OP_MULT:  ref_result = sa * sb;
      OP_MULTU: ref_result = ua * ub;
      OP_DIV: begin
        if (b == 0) ref_result = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          ref_result = {r[31:0], q[31:0]};
        end
      end
      OP_DIVU: begin
        if (b == 0) ref_result = {a, 32'hFFFF_FFFF};
        else begin
          uq = ua / ub;
          ur = ua % ub;
          ref_result = {ur[31:0], uq[31:0]};
        end
      end
      OP_MTHI: ref_result = {a, lo};
      OP_MTLO: ref_result = {hi, a};
      default: ;
    endcase
  endfunction

  // Cycles from acceptance to the write; 0 means the op never writes.
  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] b);
    case (op)
      OP_MULT, OP_MULTU, OP_MTHI, OP_MTLO: ref_latency = 1;
      OP_DIV, OP_DIVU: ref_latency = (b == 0) ? 1 : 33;
      default: ref_latency = 0;
    endcase
  endfunction

  function automatic int ref_stalls(input logic [2:0] op, input logic [31:0] b);
    ref_stalls = (op == OP_DIV || op == OP_DIVU) ? ref_latency(op, b) : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one op like a pipeline would: held while stalled, withdrawn once the stall clears.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, b, hi, lo, input int max_cyc,
                        output logic seen, output int lat, output int stalls,
                        output logic stall_at_we, output logic [63:0] data);
    logic cur_stall;
    seen = 1'b0; lat = -1; stalls = 0; stall_at_we = 1'b0; data = '0;
    bus.op_valid = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b; bus.hi_in = hi; bus.lo_in = lo;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      cur_stall = bus.stall_req;
      if (cur_stall) stalls++;
      if (bus.hilo_we && !seen) begin
        seen = 1'b1; lat = c; data = bus.hilo_data; stall_at_we = cur_stall;
      end
      tick();
      if (!cur_stall) bus.op_valid = 1'b0;
      if (seen) break;
    end
    bus.op_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.op_valid = 1'b0; bus.op = OP_NOP; bus.flush = 1'b0;
    bus.src_a = '0; bus.src_b = '0; bus.hi_in = '0; bus.lo_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", bus.stall_req); end
    n_checks++;
    if (bus.hilo_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", bus.hilo_we); end
    n_checks++;
    if (bus.hilo_data !== 64'd0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", bus.hilo_data); end
    rst = 1'b1;
    tick();
  endtask

  // Directed op with latency, stall count and data all checked against the reference.
  task automatic directed(input string name, input logic [2:0] op, input logic [31:0] a, b, hi, lo);
    logic seen, stall_at_we;
    int lat, stalls;
    logic [63:0] data, exp;
    exp = ref_result(op, a, b, hi, lo);
    run_op(op, a, b, hi, lo, 40, seen, lat, stalls, stall_at_we, data);
    n_checks++;
    if (!seen || lat != ref_latency(op, b))
      begin n_fail++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, ref_latency(op, b)); end
    n_checks++;
    if (data !== exp) begin n_fail++; $display("FAIL %s_data: got %h expected %h", name, data, exp); end
    n_checks++;
    if (stalls != ref_stalls(op, b) || stall_at_we !== 1'b0)
      begin n_fail++; $display("FAIL %s_stall: got %0d cycles (at write %b) expected %0d (at write 0)",
                              name, stalls, stall_at_we, ref_stalls(op, b)); end
    @(negedge clk);
    n_checks++;
    if (bus.hilo_we !== 1'b0) begin n_fail++; $display("FAIL %s_we_pulse: got %b expected 0", name, bus.hilo_we); end
    tick();
  endtask

  task automatic test_mult();
    directed("mult",  OP_MULT,  32'hFFFF_FFFE, 32'd3, 32'h0, 32'h0);
    directed("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0, 32'h0);
  endtask

  task automatic test_divide();
    directed("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'h0, 32'h0);
    directed("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0);
    directed("div_5_0",    OP_DIV,  32'd5, 32'd0, 32'h0, 32'h0);
    directed("divu_9_0",   OP_DIVU, 32'd9, 32'd0, 32'h0, 32'h0);
    directed("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0);
    directed("div_7_m2",   OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'h0, 32'h0);
  endtask

  task automatic test_nop();
    logic seen, stall_at_we;
    int lat, stalls;
    logic [63:0] data;
    for (int k = 0; k < 2; k++) begin
      run_op((k == 0) ? OP_NOP : OP_RSV, $urandom, $urandom, $urandom, $urandom, 4,
             seen, lat, stalls, stall_at_we, data);
      n_checks++;
      if (seen || stalls != 0)
        begin n_fail++; $display("FAIL nop_%0d: got write=%b stalls=%0d expected write=0 stalls=0", k, seen, stalls); end
    end
  endtask

  task automatic test_flush();
    int we_seen = 0;
    int stall_hi = 0;
    bus.op_valid = 1'b1; bus.op = OP_DIVU; bus.src_a = 32'd1000; bus.src_b = 32'd3;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.stall_req) stall_hi++;
      if (bus.hilo_we) we_seen++;
      tick();
    end
    bus.flush = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.stall_req !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b expected 0", bus.stall_req); end
    if (bus.hilo_we) we_seen++;
    tick();
    bus.flush = 1'b0; bus.op = OP_MTLO; bus.src_a = 32'h1234; bus.hi_in = 32'hAAAA; bus.lo_in = 32'h5A5A_5A5A;
    @(negedge clk);
    n_checks++;
    if (bus.stall_req !== 1'b0) begin n_fail++; $display("FAIL flush_mtlo_stall: got %b expected 0", bus.stall_req); end
    if (bus.hilo_we) we_seen++;
    tick();
    bus.op_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.hilo_we !== 1'b1 || bus.hilo_data !== 64'h0000_AAAA_0000_1234)
      begin n_fail++; $display("FAIL flush_mtlo: got we=%b data=%h expected we=1 data=0000aaaa00001234",
                              bus.hilo_we, bus.hilo_data); end
    tick();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.hilo_we) we_seen++;
      tick();
    end
    n_checks++;
    if (we_seen != 0 || stall_hi != 10)
      begin n_fail++; $display("FAIL flush_div: got stray writes=%0d stall cycles=%0d expected 0 and 10", we_seen, stall_hi); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp0, exp1;
    exp0 = ref_result(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 32'h0);
    exp1 = ref_result(OP_MTHI, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0BAD_F00D);
    bus.op_valid = 1'b1; bus.op = OP_MULTU; bus.src_a = 32'h1234_5678; bus.src_b = 32'h9ABC_DEF0;
    tick();
    bus.op = OP_MTHI; bus.src_a = 32'hDEAD_BEEF; bus.lo_in = 32'h0BAD_F00D;
    @(negedge clk);
    n_checks++;
    if (bus.hilo_we !== 1'b1 || bus.hilo_data !== exp0)
      begin n_fail++; $display("FAIL b2b_first: got we=%b data=%h expected we=1 data=%h", bus.hilo_we, bus.hilo_data, exp0); end
    tick();
    bus.op_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.hilo_we !== 1'b1 || bus.hilo_data !== exp1)
      begin n_fail++; $display("FAIL b2b_second: got we=%b data=%h expected we=1 data=%h", bus.hilo_we, bus.hilo_data, exp1); end
    tick();
  endtask

  task automatic test_async_reset();
    bus.op_valid = 1'b1; bus.op = OP_DIVU; bus.src_a = 32'd1000; bus.src_b = 32'd3;
    repeat (6) tick();
    #2;
    n_checks++;
    if (bus.stall_req !== 1'b1) begin n_fail++; $display("FAIL arst_pre_stall: got %b expected 1", bus.stall_req); end
    rst = 1'b0;
    bus.op_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.stall_req !== 1'b0 || bus.hilo_we !== 1'b0 || bus.hilo_data !== 64'd0)
      begin n_fail++; $display("FAIL arst_outputs: got stall=%b we=%b data=%h expected all 0",
                              bus.stall_req, bus.hilo_we, bus.hilo_data); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
    directed("arst_mthi", OP_MTHI, 32'h0000_CAFE, 32'h0, 32'h0, 32'h0000_0055);
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        seen, stall_at_we;
    int          lat, stalls, exp_lat;
    logic [63:0] data, exp;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'h0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      hi = $urandom;
      lo = $urandom;
      exp     = ref_result(op, a, b, hi, lo);
      exp_lat = ref_latency(op, b);
      run_op(op, a, b, hi, lo, (exp_lat == 0) ? 4 : 40, seen, lat, stalls, stall_at_we, data);
      n_checks++;
      if (seen !== (exp_lat != 0) || (seen && lat != exp_lat))
        begin n_fail++; $display("FAIL rand%0d_op%0d_latency: got write=%b lat=%0d expected lat=%0d", i, op, seen, lat, exp_lat); end
      n_checks++;
      if (stalls != ref_stalls(op, b))
        begin n_fail++; $display("FAIL rand%0d_op%0d_stall: got %0d expected %0d", i, op, stalls, ref_stalls(op, b)); end
      if (exp_lat != 0) begin
        n_checks++;
        if (data !== exp)
          begin n_fail++; $display("FAIL rand%0d_op%0d_data a=%h b=%h: got %h expected %h", i, op, a, b, data, exp); end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mult();
    test_divide();
    test_nop();
    test_flush();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
